// File: rtl/pcileech_tlps_pkg.sv
// -----------------------------------------------------------------------------
// pcileech_tlps_pkg
// Shared types for the 128-bit TLP AXI-Stream path.
//   tlp_beat_t  : one stored stream beat {tdata, tkeepdw, tuser, tlast}
//   TLP_BEAT_W  : stored beat width in bits (128 + 4 + 9 + 1)
// -----------------------------------------------------------------------------
package pcileech_tlps_pkg;

    typedef struct packed {
        logic [127:0] tdata;
        logic [3:0]   tkeepdw;
        logic [8:0]   tuser;
        logic         tlast;
    } tlp_beat_t;

    localparam int unsigned TLP_BEAT_W = $bits(tlp_beat_t);

endpackage

// File: rtl/pcileech_tlps128_absorb_fifo.sv
// -----------------------------------------------------------------------------
// pcileech_tlps128_absorb_fifo
// Synchronous first-word-fall-through FIFO with full/empty flags.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   wr_en_i, wr_data_i : write request and data (ignored while full)
//   rd_en_i            : pop the head entry (ignored while empty)
//   rd_data_o          : head entry, valid whenever empty_o is low
//   full_o, empty_o    : occupancy flags, functions of registered pointers only
// -----------------------------------------------------------------------------
module pcileech_tlps128_absorb_fifo
    import pcileech_tlps_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = TLP_BEAT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_fire;
    logic             rd_fire;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign wr_fire = wr_en_i && !full_o;
    assign rd_fire = rd_en_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_fire) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        if (rd_fire) rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset; contents are only observed when not empty.
    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/pcileech_tlps128_jitter_absorb.sv
// -----------------------------------------------------------------------------
// pcileech_tlps128_jitter_absorb
// Store-and-forward elastic buffer on the 128-bit TLP stream: absorbs input
// bubbles and re-emits each TLP as a contiguous burst. If the FIFO fills with
// no complete packet inside, the packet is released in cut-through mode so
// TLPs longer than DEPTH cannot deadlock.
// Build option: define PCILEECH_JITTER_ABSORB_STATS_EN to implement the
// bubble/force statistics counters; otherwise both outputs read 0.
// Ports:
//   clk_pcie, rst          : clock, synchronous active-high reset
//   tlps_in_*_i/_o         : sink side (has_data is ignored), tready = !full
//   tlps_out_*_o/_i        : source side, has_data = FIFO not empty
//   bubble_cnt_o           : saturating count of absorbed input bubbles
//   force_cnt_o            : saturating count of cut-through releases
// -----------------------------------------------------------------------------
module pcileech_tlps128_jitter_absorb
    import pcileech_tlps_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_pcie,
    input  logic             rst,
    input  logic [127:0]     tlps_in_tdata_i,
    input  logic [3:0]       tlps_in_tkeepdw_i,
    input  logic [8:0]       tlps_in_tuser_i,
    input  logic             tlps_in_tlast_i,
    input  logic             tlps_in_has_data_i,
    input  logic             tlps_in_tvalid_i,
    output logic             tlps_in_tready_o,
    output logic [127:0]     tlps_out_tdata_o,
    output logic [3:0]       tlps_out_tkeepdw_o,
    output logic [8:0]       tlps_out_tuser_o,
    output logic             tlps_out_tlast_o,
    output logic             tlps_out_has_data_o,
    output logic             tlps_out_tvalid_o,
    input  logic             tlps_out_tready_i,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] force_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;

    tlp_beat_t     wr_beat;
    tlp_beat_t     rd_beat;
    logic          fifo_full;
    logic          fifo_empty;
    logic          wr_fire;
    logic          rd_fire;
    logic          force_set;
    logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          out_busy_q, out_busy_d;
    logic          force_q, force_d;
    logic          unused_has_data;

    assign unused_has_data = tlps_in_has_data_i;

    assign wr_beat = '{tdata:   tlps_in_tdata_i,
                       tkeepdw: tlps_in_tkeepdw_i,
                       tuser:   tlps_in_tuser_i,
                       tlast:   tlps_in_tlast_i};

    pcileech_tlps128_absorb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TLP_BEAT_W)
    ) u_fifo (
        .clk_i     (clk_pcie),
        .rst_i     (rst),
        .wr_en_i   (wr_fire),
        .wr_data_i (wr_beat),
        .rd_en_i   (rd_fire),
        .rd_data_o (rd_beat),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign tlps_in_tready_o    = !fifo_full;
    assign wr_fire             = tlps_in_tvalid_i && !fifo_full;

    assign tlps_out_tvalid_o   = !fifo_empty && ((pkt_cnt_q != '0) || out_busy_q || force_q);
    assign tlps_out_has_data_o = !fifo_empty;
    assign tlps_out_tdata_o    = rd_beat.tdata;
    assign tlps_out_tkeepdw_o  = rd_beat.tkeepdw;
    assign tlps_out_tuser_o    = rd_beat.tuser;
    assign tlps_out_tlast_o    = rd_beat.tlast;
    assign rd_fire             = tlps_out_tvalid_o && tlps_out_tready_i;

    // FIFO jammed with a partial packet and nothing draining: cut through.
    assign force_set = fifo_full && (pkt_cnt_q == '0) && !out_busy_q && !force_q;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        out_busy_d = out_busy_q;
        force_d    = force_q;
        if ((wr_fire && tlps_in_tlast_i) && !(rd_fire && rd_beat.tlast)) begin
            pkt_cnt_d = pkt_cnt_q + PW'(1);
        end else if (!(wr_fire && tlps_in_tlast_i) && (rd_fire && rd_beat.tlast)) begin
            pkt_cnt_d = pkt_cnt_q - PW'(1);
        end
        if (rd_fire) begin
            out_busy_d = !rd_beat.tlast;
            if (rd_beat.tlast) force_d = 1'b0;
        end
        if (force_set) force_d = 1'b1;
    end

    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            out_busy_q <= 1'b0;
            force_q    <= 1'b0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            out_busy_q <= out_busy_d;
            force_q    <= force_d;
        end
    end

`ifdef PCILEECH_JITTER_ABSORB_STATS_EN
    // Input packet is open between an accepted non-last beat and its tlast.
    logic             pkt_open_q, pkt_open_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] force_cnt_q, force_cnt_d;

    always_comb begin
        pkt_open_d   = pkt_open_q;
        bubble_cnt_d = bubble_cnt_q;
        force_cnt_d  = force_cnt_q;
        if (wr_fire) pkt_open_d = !tlps_in_tlast_i;
        if (pkt_open_q && !wr_fire && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
        if (force_set && (force_cnt_q != '1)) force_cnt_d = force_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            pkt_open_q   <= 1'b0;
            bubble_cnt_q <= '0;
            force_cnt_q  <= '0;
        end else begin
            pkt_open_q   <= pkt_open_d;
            bubble_cnt_q <= bubble_cnt_d;
            force_cnt_q  <= force_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign force_cnt_o  = force_cnt_q;
`else
    assign bubble_cnt_o = '0;
    assign force_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pcileech_tlps128_jitter_absorb.sv
// -----------------------------------------------------------------------------
// tb_pcileech_tlps128_jitter_absorb
// Self-checking bench: a vector table for single-beat latency and bubble
// absorption, directed sequences for stall, cut-through and reset, and a
// randomized run checked cycle by cycle against a queue-based model.
// Inputs change 1 ns after posedge; everything is sampled on negedge.
// -----------------------------------------------------------------------------
module tb_pcileech_tlps128_jitter_absorb;
    import pcileech_tlps_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned CNT_W = 32;
`ifdef PCILEECH_JITTER_ABSORB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [127:0]     in_tdata = '0;
    logic [3:0]       in_tkeepdw = '0;
    logic [8:0]       in_tuser = '0;
    logic             in_tlast = 1'b0;
    logic             in_has_data = 1'b0;
    logic             in_tvalid = 1'b0;
    logic             in_tready;
    logic [127:0]     out_tdata;
    logic [3:0]       out_tkeepdw;
    logic [8:0]       out_tuser;
    logic             out_tlast;
    logic             out_has_data;
    logic             out_tvalid;
    logic             out_tready = 1'b1;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] force_cnt;

    always #5 clk = ~clk;

    pcileech_tlps128_jitter_absorb #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_pcie            (clk),
        .rst                 (rst),
        .tlps_in_tdata_i     (in_tdata),
        .tlps_in_tkeepdw_i   (in_tkeepdw),
        .tlps_in_tuser_i     (in_tuser),
        .tlps_in_tlast_i     (in_tlast),
        .tlps_in_has_data_i  (in_has_data),
        .tlps_in_tvalid_i    (in_tvalid),
        .tlps_in_tready_o    (in_tready),
        .tlps_out_tdata_o    (out_tdata),
        .tlps_out_tkeepdw_o  (out_tkeepdw),
        .tlps_out_tuser_o    (out_tuser),
        .tlps_out_tlast_o    (out_tlast),
        .tlps_out_has_data_o (out_has_data),
        .tlps_out_tvalid_o   (out_tvalid),
        .tlps_out_tready_i   (out_tready),
        .bubble_cnt_o        (bubble_cnt),
        .force_cnt_o         (force_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [TLP_BEAT_W-1:0] act,
                       input logic [TLP_BEAT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    tlp_beat_t in_beat, out_beat;
    assign in_beat  = {in_tdata, in_tkeepdw, in_tuser, in_tlast};
    assign out_beat = {out_tdata, out_tkeepdw, out_tuser, out_tlast};

    function automatic logic [CNT_W-1:0] sat(input longint v);
        longint lim;
        lim = (longint'(1) << CNT_W) - 1;
        return (v >= lim) ? CNT_W'(lim) : CNT_W'(v);
    endfunction

    // ---------------- reference model (beat queue + packet rules) ------------
    tlp_beat_t mq[$];
    tlp_beat_t rxq[$];
    bit        model_on = 1'b0;
    bit        m_busy = 1'b0, m_force = 1'b0, m_open = 1'b0;
    longint    m_bub = 0, m_frc = 0;
    int        n_wr = 0;

    always @(negedge clk) begin : model
        int nlast;
        bit e_rdy, e_val, wr, rd, set_f;
        nlast = 0;
        foreach (mq[i]) if (mq[i].tlast) nlast++;
        e_rdy = (mq.size() < DEPTH);
        e_val = (mq.size() != 0) && (nlast != 0 || m_busy || m_force);
        if (model_on) begin
            chk("m_in_tready", in_tready, e_rdy);
            chk("m_out_tvalid", out_tvalid, e_val);
            chk("m_has_data", out_has_data, mq.size() != 0);
            if (e_val && out_tvalid) chk("m_out_beat", out_beat, mq[0]);
            chk("m_bubble_cnt", bubble_cnt, STATS ? sat(m_bub) : '0);
            chk("m_force_cnt", force_cnt, STATS ? sat(m_frc) : '0);
        end
        if (!rst && out_tvalid && out_tready) rxq.push_back(out_beat);
        if (!rst && in_tvalid && in_tready) n_wr++;
        if (rst) begin
            mq.delete();
            m_busy = 0; m_force = 0; m_open = 0; m_bub = 0; m_frc = 0;
        end else begin
            wr    = in_tvalid && e_rdy;
            rd    = e_val && out_tready;
            set_f = (mq.size() == DEPTH) && (nlast == 0) && !m_busy && !m_force;
            if (set_f) m_frc++;
            if (m_open && !wr) m_bub++;
            if (rd) begin
                if (mq[0].tlast) begin
                    m_busy = 0; m_force = 0;
                end else begin
                    m_busy = 1;
                end
                void'(mq.pop_front());
            end
            if (set_f) m_force = 1;
            if (wr) begin
                mq.push_back(in_beat);
                m_open = !in_beat.tlast;
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    function automatic tlp_beat_t mk(input int tag, input bit last);
        tlp_beat_t b;
        b.tdata   = {$urandom, $urandom, $urandom, 32'(tag)};
        b.tkeepdw = 4'($urandom);
        b.tuser   = 9'($urandom);
        b.tlast   = last;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input tlp_beat_t b, input bit v);
        {in_tdata, in_tkeepdw, in_tuser, in_tlast} = b;
        in_tvalid = v;
    endtask

    task automatic step_beat(input tlp_beat_t b, output bit acc);
        put(b, 1'b1);
        @(negedge clk);
        acc = in_tready;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_tvalid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit       v;
        bit       last;
        int       tag;
        bit       e_val;
        bit       e_last;
        int       e_tag;
    } vec_t;

    function automatic vec_t row(input bit v, input bit last, input int tag,
                                 input bit e_val, input bit e_last, input int e_tag);
        vec_t r;
        r.v = v; r.last = last; r.tag = tag;
        r.e_val = e_val; r.e_last = e_last; r.e_tag = e_tag;
        return r;
    endfunction

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t      tbl[$];
        tlp_beat_t b;
        bit        acc;
        int        k, rx0, bad, nl, plen, pos, tag;

        // single-beat TLP at cycle 10, then 4-beat TLP with two bubbles
        for (int i = 0; i < 10; i++) tbl.push_back(row(0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 1, 'h100, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 1, 'h100));
        tbl.push_back(row(0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 0, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 0, 2, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 0, 3, 0, 0, 0));
        tbl.push_back(row(1, 1, 4, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 0, 1));
        tbl.push_back(row(0, 0, 0, 1, 0, 2));
        tbl.push_back(row(0, 0, 0, 1, 0, 3));
        tbl.push_back(row(0, 0, 0, 1, 1, 4));
        tbl.push_back(row(0, 0, 0, 0, 0, 0));

        rst = 1'b1;
        tick();
        tick();
        model_on = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tready", in_tready, 1'b1);
        chk("rst_tvalid", out_tvalid, 1'b0);
        chk("rst_has_data", out_has_data, 1'b0);
        chk("rst_bubble_cnt", bubble_cnt, '0);
        chk("rst_force_cnt", force_cnt, '0);
        tick();

        out_tready = 1'b1;
        foreach (tbl[i]) begin
            b = mk(tbl[i].tag, tbl[i].last);
            b.tkeepdw = 4'h7;
            put(b, tbl[i].v);
            @(negedge clk);
            chk($sformatf("tbl%0d_tready", i), in_tready, 1'b1);
            chk($sformatf("tbl%0d_tvalid", i), out_tvalid, tbl[i].e_val);
            if (tbl[i].e_val) begin
                chk($sformatf("tbl%0d_tag", i), out_tdata[31:0], 32'(tbl[i].e_tag));
                chk($sformatf("tbl%0d_tlast", i), out_tlast, tbl[i].e_last);
                chk($sformatf("tbl%0d_keep", i), out_tkeepdw, 4'h7);
            end
            tick();
        end
        in_tvalid = 1'b0;
        @(negedge clk);
        chk("bubble_cnt_after_tbl", bubble_cnt, STATS ? CNT_W'(2) : '0);
        tick();

        // back-to-back 2-beat TLPs into a stalled output
        do_reset();
        out_tready = 1'b0;
        k = 0;
        for (int c = 0; c < 70; c++) begin
            step_beat(mk(k, k[0]), acc);
            if (acc) k++;
        end
        in_tvalid = 1'b0;
        chk("stall_stored", k, 64);
        @(negedge clk);
        chk("stall_tready_low", in_tready, 1'b0);
        tick();
        rx0 = rxq.size();
        out_tready = 1'b1;
        for (int c = 0; c < 200 && rxq.size() < rx0 + 64; c++) tick();
        chk("stall_drained", rxq.size() - rx0, 64);
        bad = 0; nl = 0;
        for (int i = 0; i < 64 && rx0 + i < rxq.size(); i++) begin
            if (rxq[rx0 + i].tdata[31:0] != 32'(i)) bad++;
            if (rxq[rx0 + i].tlast) nl++;
        end
        chk("stall_order", bad, 0);
        chk("stall_packets", nl, 32);

        // 80-beat TLP forces cut-through
        do_reset();
        out_tready = 1'b1;
        rx0 = rxq.size();
        k = 0;
        for (int c = 0; c < 400 && k < 80; c++) begin
            step_beat(mk(k, k == 79), acc);
            if (acc) k++;
        end
        in_tvalid = 1'b0;
        chk("force_fed", k, 80);
        for (int c = 0; c < 200 && rxq.size() < rx0 + 80; c++) tick();
        chk("force_delivered", rxq.size() - rx0, 80);
        bad = 0;
        for (int i = 0; i < 80 && rx0 + i < rxq.size(); i++) begin
            if (rxq[rx0 + i].tdata[31:0] != 32'(i)) bad++;
        end
        chk("force_order", bad, 0);
        @(negedge clk);
        chk("force_cnt", force_cnt, STATS ? CNT_W'(1) : '0);
        tick();

        // following 2-beat TLP goes back to store-and-forward
        put(mk(500, 0), 1'b1);
        tick();
        in_tvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("sf_hold", out_tvalid, 1'b0);
            tick();
        end
        put(mk(501, 1), 1'b1);
        @(negedge clk);
        chk("sf_hold_last", out_tvalid, 1'b0);
        tick();
        in_tvalid = 1'b0;
        @(negedge clk);
        chk("sf_first_valid", out_tvalid, 1'b1);
        chk("sf_first_tag", out_tdata[31:0], 32'd500);
        tick();
        @(negedge clk);
        chk("sf_second_valid", out_tvalid, 1'b1);
        chk("sf_second_tag", out_tdata[31:0], 32'd501);
        tick();

        // reset after 2 of 4 beats; counters still hold earlier values here
        put(mk(600, 0), 1'b1);
        tick();
        put(mk(601, 0), 1'b1);
        tick();
        do_reset();
        @(negedge clk);
        chk("midrst_tvalid", out_tvalid, 1'b0);
        chk("midrst_tready", in_tready, 1'b1);
        chk("midrst_bubble_cnt", bubble_cnt, '0);
        chk("midrst_force_cnt", force_cnt, '0);
        tick();
        put(mk(700, 1), 1'b1);
        tick();
        in_tvalid = 1'b0;
        @(negedge clk);
        chk("midrst_after_valid", out_tvalid, 1'b1);
        chk("midrst_after_tag", out_tdata[31:0], 32'd700);
        tick();

        // randomized traffic, checked every cycle by the model
        do_reset();
        rx0 = rxq.size();
        k = n_wr;
        plen = 3; pos = 0; tag = 0;
        for (int c = 0; c < 4000; c++) begin
            out_tready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 7) begin
                step_beat(mk(tag, pos == plen - 1), acc);
                if (acc) begin
                    tag++;
                    pos++;
                    if (pos == plen) begin
                        pos = 0;
                        plen = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 100))
                                                           : int'($urandom_range(1, 8));
                    end
                end
            end else begin
                in_tvalid = 1'b0;
                tick();
            end
        end
        in_tvalid = 1'b0;
        out_tready = 1'b1;
        repeat (150) tick();
        chk("rand_conservation", rxq.size() - rx0 + mq.size(), n_wr - k);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
